// File: rtl/sal_tlp_tx_ctrl_pkg.sv
// Shared types and helpers for the SAL TLP transmit path.
package sal_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    DATA,
    DONE
  } tx_state_t;

  localparam int FMT_W      = 3;
  localparam int TYPE_W     = 5;
  localparam int TC_W       = 3;
  localparam int LEN_FLD_W  = 9;
  localparam int ID_W       = 16;
  localparam int MAX_PLD_DW = 512;

  // Header DW0 layout: fmt | type | rsvd | tc | 11 reserved bits | length.
  function automatic logic [31:0] build_dw0(
    input logic [FMT_W-1:0]     fmt,
    input logic [TYPE_W-1:0]    typ,
    input logic [TC_W-1:0]      tc,
    input logic [LEN_FLD_W-1:0] len
  );
    return {fmt, typ, 1'b0, tc, 11'b0, len};
  endfunction

endpackage

// File: rtl/sal_tlp_tx_ctrl_if.sv
// Payload-source and link-layer stream signals of the TLP transmit controller.
interface sal_tlp_tx_ctrl_if #(
  parameter int DW_W = 32
) ();
  logic            pld_valid_i;
  logic [DW_W-1:0] pld_data_i;
  logic            pld_ready_o;
  logic            tx_valid_o;
  logic [DW_W-1:0] tx_data_o;
  logic            tx_sop_o;
  logic            tx_eop_o;
  logic            tx_ready_i;

  modport master (
    input  pld_valid_i, pld_data_i, tx_ready_i,
    output pld_ready_o, tx_valid_o, tx_data_o, tx_sop_o, tx_eop_o
  );

  modport slave (
    output pld_valid_i, pld_data_i, tx_ready_i,
    input  pld_ready_o, tx_valid_o, tx_data_o, tx_sop_o, tx_eop_o
  );
endinterface

// File: rtl/sal_tlp_hdr_pack.sv
// Combinational packing of the latched header fields into the two header DWs.
module sal_tlp_hdr_pack
  import sal_pkg::*;
#(
  parameter int LEN_W = 9
) (
  input  logic [FMT_W-1:0]  fmt,
  input  logic [TYPE_W-1:0] typ,
  input  logic [TC_W-1:0]   tc,
  input  logic [LEN_W-1:0]  len,
  input  logic [ID_W-1:0]   req_id,
  input  logic [ID_W-1:0]   cpl_id,
  output logic [31:0]       dw0,
  output logic [31:0]       dw1
);
  assign dw0 = build_dw0(fmt, typ, tc, LEN_FLD_W'(len));
  assign dw1 = {req_id, cpl_id};
endmodule

// File: rtl/sal_tlp_tx_ctrl.sv
// Channel-0 TLP transmit controller: snapshots header config on start and
// emits two header DWs plus optional payload on a valid/ready stream.
module sal_tlp_tx_ctrl
  import sal_pkg::*;
#(
  parameter int DW_W  = 32,
  parameter int LEN_W = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ch0_start_i,
  input  logic [FMT_W-1:0]     header_fmt_c,
  input  logic [TYPE_W-1:0]    header_type_c,
  input  logic [TC_W-1:0]      header_tc_c,
  input  logic [LEN_W-1:0]     header_length_c,
  input  logic [ID_W-1:0]      header_requestID_c,
  input  logic [ID_W-1:0]      header_completID_c,
  sal_tlp_tx_ctrl_if.master    bus,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 start_drop_o
);
  localparam int CNT_W = LEN_W + 1;

  tx_state_t         state_q;
  logic [FMT_W-1:0]  fmt_q;
  logic [TYPE_W-1:0] type_q;
  logic [TC_W-1:0]   tc_q;
  logic [LEN_W-1:0]  len_q;
  logic [ID_W-1:0]   req_id_q;
  logic [ID_W-1:0]   cpl_id_q;
  logic              has_data_q;
  logic [CNT_W-1:0]  remaining_q;
  logic              busy_q;
  logic              done_q;
  logic              drop_q;

  logic [31:0]       dw0;
  logic [31:0]       dw1;
  logic              tx_valid;
  logic [DW_W-1:0]   tx_data;
  logic              tx_sop;
  logic              tx_eop;
  logic              pld_ready;
  logic              last_pld;

  sal_tlp_hdr_pack #(.LEN_W(LEN_W)) u_hdr_pack (
    .fmt    (fmt_q),
    .typ    (type_q),
    .tc     (tc_q),
    .len    (len_q),
    .req_id (req_id_q),
    .cpl_id (cpl_id_q),
    .dw0    (dw0),
    .dw1    (dw1)
  );

  assign last_pld = (remaining_q == CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      fmt_q       <= '0;
      type_q      <= '0;
      tc_q        <= '0;
      len_q       <= '0;
      req_id_q    <= '0;
      cpl_id_q    <= '0;
      has_data_q  <= 1'b0;
      remaining_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      drop_q <= ch0_start_i && (state_q != IDLE);
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ch0_start_i) begin
            fmt_q       <= header_fmt_c;
            type_q      <= header_type_c;
            tc_q        <= header_tc_c;
            len_q       <= header_length_c;
            req_id_q    <= header_requestID_c;
            cpl_id_q    <= header_completID_c;
            has_data_q  <= header_fmt_c[1];
            // A zero length field encodes the maximum payload.
            remaining_q <= (header_length_c == '0) ? CNT_W'(MAX_PLD_DW)
                                                   : {1'b0, header_length_c};
            busy_q      <= 1'b1;
            state_q     <= HDR0;
          end
        end
        HDR0: begin
          if (bus.tx_ready_i) state_q <= HDR1;
        end
        HDR1: begin
          if (bus.tx_ready_i) begin
            if (has_data_q) begin
              state_q <= DATA;
            end else begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        DATA: begin
          if (bus.pld_valid_i && bus.tx_ready_i) begin
            remaining_q <= remaining_q - CNT_W'(1);
            if (last_pld) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Headers come from latched fields; payload is a straight pass-through.
  always_comb begin
    tx_valid  = 1'b0;
    tx_data   = '0;
    tx_sop    = 1'b0;
    tx_eop    = 1'b0;
    pld_ready = 1'b0;
    case (state_q)
      HDR0: begin
        tx_valid = 1'b1;
        tx_data  = dw0;
        tx_sop   = 1'b1;
      end
      HDR1: begin
        tx_valid = 1'b1;
        tx_data  = dw1;
        tx_eop   = !has_data_q;
      end
      DATA: begin
        tx_valid  = bus.pld_valid_i;
        tx_data   = bus.pld_data_i;
        tx_eop    = last_pld;
        pld_ready = bus.tx_ready_i;
      end
      default: ;
    endcase
  end

  assign bus.tx_valid_o  = tx_valid;
  assign bus.tx_data_o   = tx_data;
  assign bus.tx_sop_o    = tx_sop;
  assign bus.tx_eop_o    = tx_eop;
  assign bus.pld_ready_o = pld_ready;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign start_drop_o    = drop_q;

endmodule
